// File: rtl/mem_port_arbiter_if.sv
// Request/response handshake for both ports plus the single-port memory bus.
// slave = the arbiter; master = requesters together with the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output ack0, rvalid0, rdata0,
    output ack1, rvalid1, rdata1,
    output mem_addr, mem_wdata, mem_wren,
    output busy, grant_id
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  ack0, rvalid0, rdata0,
    input  ack1, rvalid1, rdata1,
    input  mem_addr, mem_wdata, mem_wren,
    input  busy, grant_id
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one synchronous
// single-port memory; one access in flight, read data returned with a pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic              r_ack0,     w_ack0;
  logic              r_ack1,     w_ack1;
  logic              r_rvalid0,  w_rvalid0;
  logic              r_rvalid1,  w_rvalid1;
  logic [DATA_W-1:0] r_rdata0,   w_rdata0;
  logic [DATA_W-1:0] r_rdata1,   w_rdata1;
  logic [ADDR_W-1:0] r_addr,     w_addr;
  logic [DATA_W-1:0] r_wdata,    w_wdata;
  logic              r_wren,     w_wren;
  logic              r_busy,     w_busy;
  logic              r_grant_id, w_grant_id;
  logic              w_pick1;

  // Next-state and next-output logic; every output is a register fed from here.
  always_comb begin
    w_state_nxt = r_state;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    w_rvalid0   = 1'b0;
    w_rvalid1   = 1'b0;
    w_rdata0    = r_rdata0;
    w_rdata1    = r_rdata1;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wren      = 1'b0;
    w_grant_id  = r_grant_id;
    w_pick1     = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contested: the port that did not own the last access wins.
          w_pick1     = bus.req1 && (!bus.req0 || !r_grant_id);
          w_grant_id  = w_pick1;
          w_ack0      = !w_pick1;
          w_ack1      = w_pick1;
          w_addr      = w_pick1 ? bus.addr1  : bus.addr0;
          w_wdata     = w_pick1 ? bus.wdata1 : bus.wdata0;
          w_wren      = w_pick1 ? bus.we1    : bus.we0;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = r_wren ? IDLE : CAPTURE;
      end
      CAPTURE: begin
        if (r_grant_id) begin
          w_rvalid1 = 1'b1;
          w_rdata1  = bus.mem_q;
        end else begin
          w_rvalid0 = 1'b1;
          w_rdata0  = bus.mem_q;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy = (w_state_nxt != IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state    <= IDLE;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_busy     <= 1'b0;
      r_grant_id <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_ack0     <= w_ack0;
      r_ack1     <= w_ack1;
      r_rvalid0  <= w_rvalid0;
      r_rvalid1  <= w_rvalid1;
      r_rdata0   <= w_rdata0;
      r_rdata1   <= w_rdata1;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_wren     <= w_wren;
      r_busy     <= w_busy;
      r_grant_id <= w_grant_id;
    end
  end

  assign bus.ack0      = r_ack0;
  assign bus.ack1      = r_ack1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wren  = r_wren;
  assign bus.busy      = r_busy;
  assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table against a
// 256x16 synchronous memory model, plus hand sequences for multi-cycle cases.
module tb_mem_port_arbiter;

  logic Clock;
  logic Resetn;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Observed outputs, packed so one vector row is one comparison.
  typedef struct packed {
    logic        ack0;
    logic        ack1;
    logic        rvalid0;
    logic        rvalid1;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wren;
    logic        busy;
    logic        grant_id;
  } obs_t;

  typedef struct {
    string       tag;
    bit          rst;
    bit          req0;
    bit          we0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    bit          req1;
    bit          we1;
    logic [7:0]  addr1;
    logic [15:0] wdata1;
    obs_t        exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Memory model: address/data/we captured at the edge, q valid next cycle.
  logic [15:0] mem [256];
  bit          mem_init;
  always @(posedge Clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h01] <= 16'h1111;
      mem[8'h02] <= 16'h2222;
      mem[8'h40] <= 16'h1234;
      mem[8'h41] <= 16'h5555;
      mem_init   <= 1'b1;
      bus.mem_q  <= 16'h0000;
    end else begin
      if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_q <= mem[bus.mem_addr];
    end
  end

  // Cross-port exclusivity and write-enable confinement, every cycle.
  always @(negedge Clock) begin
    if (Resetn) begin
      checks++;
      if ((bus.ack0 && bus.ack1) || (bus.rvalid0 && bus.rvalid1) ||
          (bus.ack0 && bus.rvalid0) || (bus.ack1 && bus.rvalid1) ||
          (bus.mem_wren && !bus.busy)) begin
        failures++;
        $display("FAIL exclusivity t=%0t: ack=%b%b rvalid=%b%b wren=%b busy=%b",
                 $time, bus.ack0, bus.ack1, bus.rvalid0, bus.rvalid1,
                 bus.mem_wren, bus.busy);
      end
    end
  end

  function automatic obs_t get_obs();
    obs_t o;
    o.ack0      = bus.ack0;
    o.ack1      = bus.ack1;
    o.rvalid0   = bus.rvalid0;
    o.rvalid1   = bus.rvalid1;
    o.rdata0    = bus.rdata0;
    o.rdata1    = bus.rdata1;
    o.mem_addr  = bus.mem_addr;
    o.mem_wdata = bus.mem_wdata;
    o.mem_wren  = bus.mem_wren;
    o.busy      = bus.busy;
    o.grant_id  = bus.grant_id;
    return o;
  endfunction

  function automatic obs_t rst_obs();
    obs_t o;
    o          = '0;
    o.grant_id = 1'b1;
    return o;
  endfunction

  function automatic vec_t v(string tag, bit rst,
                             bit rq0, bit w0, logic [7:0] a0, logic [15:0] d0,
                             bit rq1, bit w1, logic [7:0] a1, logic [15:0] d1,
                             bit k0, bit k1, bit rv0, bit rv1,
                             logic [15:0] rd0, logic [15:0] rd1,
                             logic [7:0] ma, logic [15:0] mwd,
                             bit wr, bit bsy, bit gid);
    vec_t r;
    r.tag    = tag;   r.rst    = rst;
    r.req0   = rq0;   r.we0    = w0;  r.addr0 = a0; r.wdata0 = d0;
    r.req1   = rq1;   r.we1    = w1;  r.addr1 = a1; r.wdata1 = d1;
    r.exp = '{ack0: k0, ack1: k1, rvalid0: rv0, rvalid1: rv1,
              rdata0: rd0, rdata1: rd1, mem_addr: ma, mem_wdata: mwd,
              mem_wren: wr, busy: bsy, grant_id: gid};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 16'h0000;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 16'h0000;
  endtask

  task automatic do_reset();
    drive_idle();
    Resetn = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    chk("reset_state", 64'(get_obs()), 64'(rst_obs()));
  endtask

  vec_t        tbl[$];
  logic [4:0]  e5, a5;
  bit          rv_seen;

  initial begin
    Resetn = 1'b0;
    drive_idle();
    repeat (2) @(posedge Clock);
    #1;

    // Port 0 write 0x12 <- BEEF then read back; port 1 stays quiet.
    tbl.push_back(v("p0_wr",  1, 1,1,8'h12,16'hBEEF, 0,0,8'h00,16'h0, 1,0,0,0,16'h0,   16'h0,8'h12,16'hBEEF,1,1,0));
    tbl.push_back(v("p0_wr",  0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'h0,   16'h0,8'h12,16'hBEEF,0,0,0));
    tbl.push_back(v("p0_rd",  0, 1,0,8'h12,16'h0,    0,0,8'h00,16'h0, 1,0,0,0,16'h0,   16'h0,8'h12,16'h0,   0,1,0));
    tbl.push_back(v("p0_rd",  0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'h0,   16'h0,8'h12,16'h0,   0,1,0));
    tbl.push_back(v("p0_rd",  0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,1,0,16'hBEEF,16'h0,8'h12,16'h0,   0,0,0));
    tbl.push_back(v("p0_rd",  0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'hBEEF,16'h0,8'h12,16'h0,   0,0,0));
    // Both read from reset: port 0 first, port 1 stays pending.
    tbl.push_back(v("both_rd",1, 1,0,8'h01,16'h0,    1,0,8'h02,16'h0, 1,0,0,0,16'h0,   16'h0,   8'h01,16'h0,0,1,0));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    1,0,8'h02,16'h0, 0,0,0,0,16'h0,   16'h0,   8'h01,16'h0,0,1,0));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    1,0,8'h02,16'h0, 0,0,1,0,16'h1111,16'h0,   8'h01,16'h0,0,0,0));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    1,0,8'h02,16'h0, 0,1,0,0,16'h1111,16'h0,   8'h02,16'h0,0,1,1));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'h1111,16'h0,   8'h02,16'h0,0,1,1));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,1,16'h1111,16'h2222,8'h02,16'h0,0,0,1));
    tbl.push_back(v("both_rd",0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'h1111,16'h2222,8'h02,16'h0,0,0,1));
    // After a port 1 grant, p0 read and p1 write of 0x40 collide: p0 sees old data.
    tbl.push_back(v("rw_race",1, 0,0,8'h00,16'h0, 1,0,8'h41,16'h0,  0,1,0,0,16'h0,   16'h0,   8'h41,16'h0,   0,1,1));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 0,0,8'h00,16'h0,  0,0,0,0,16'h0,   16'h0,   8'h41,16'h0,   0,1,1));
    tbl.push_back(v("rw_race",0, 1,0,8'h40,16'h0, 1,1,8'h40,16'hA5, 0,0,0,1,16'h0,   16'h5555,8'h41,16'h0,   0,0,1));
    tbl.push_back(v("rw_race",0, 1,0,8'h40,16'h0, 1,1,8'h40,16'hA5, 1,0,0,0,16'h0,   16'h5555,8'h40,16'h0,   0,1,0));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 1,1,8'h40,16'hA5, 0,0,0,0,16'h0,   16'h5555,8'h40,16'h0,   0,1,0));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 1,1,8'h40,16'hA5, 0,0,1,0,16'h1234,16'h5555,8'h40,16'h0,   0,0,0));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 1,1,8'h40,16'hA5, 0,1,0,0,16'h1234,16'h5555,8'h40,16'h00A5,1,1,1));
    tbl.push_back(v("rw_race",0, 1,0,8'h40,16'h0, 0,0,8'h00,16'h0,  0,0,0,0,16'h1234,16'h5555,8'h40,16'h00A5,0,0,1));
    tbl.push_back(v("rw_race",0, 1,0,8'h40,16'h0, 0,0,8'h00,16'h0,  1,0,0,0,16'h1234,16'h5555,8'h40,16'h0,   0,1,0));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 0,0,8'h00,16'h0,  0,0,0,0,16'h1234,16'h5555,8'h40,16'h0,   0,1,0));
    tbl.push_back(v("rw_race",0, 0,0,8'h00,16'h0, 0,0,8'h00,16'h0,  0,0,1,0,16'h00A5,16'h5555,8'h40,16'h0,   0,0,0));
    // req1 raised while port 0 is in ISSUE is ignored until the next IDLE cycle.
    tbl.push_back(v("late_rq",1, 1,1,8'h50,16'h0F0F, 0,0,8'h00,16'h0, 1,0,0,0,16'h0,16'h0,   8'h50,16'h0F0F,1,1,0));
    tbl.push_back(v("late_rq",0, 0,0,8'h00,16'h0,    1,0,8'h50,16'h0, 0,0,0,0,16'h0,16'h0,   8'h50,16'h0F0F,0,0,0));
    tbl.push_back(v("late_rq",0, 0,0,8'h00,16'h0,    1,0,8'h50,16'h0, 0,1,0,0,16'h0,16'h0,   8'h50,16'h0,   0,1,1));
    tbl.push_back(v("late_rq",0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,0,16'h0,16'h0,   8'h50,16'h0,   0,1,1));
    tbl.push_back(v("late_rq",0, 0,0,8'h00,16'h0,    0,0,8'h00,16'h0, 0,0,0,1,16'h0,16'h0F0F,8'h50,16'h0,   0,0,1));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      bus.req0 = tbl[i].req0; bus.we0 = tbl[i].we0;
      bus.addr0 = tbl[i].addr0; bus.wdata0 = tbl[i].wdata0;
      bus.req1 = tbl[i].req1; bus.we1 = tbl[i].we1;
      bus.addr1 = tbl[i].addr1; bus.wdata1 = tbl[i].wdata1;
      @(posedge Clock);
      #1;
      chk($sformatf("%s[%0d]", tbl[i].tag, i), 64'(get_obs()), 64'(tbl[i].exp));
    end

    // Both ports write continuously: six grants alternating 0,1,0,1,0,1.
    do_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 16'hA000;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h31; bus.wdata1 = 16'hB000;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock);
      #1;
      e5 = {(c % 4) == 0, (c % 4) == 2, (c % 2) == 0, (c % 2) == 0, (c % 4) >= 2};
      a5 = {bus.ack0, bus.ack1, bus.busy, bus.mem_wren, bus.grant_id};
      chk($sformatf("rr_cycle%0d", c), 64'(a5), 64'(e5));
    end
    drive_idle();
    @(posedge Clock);
    #1;
    chk("rr_mem30", 64'(mem[8'h30]), 64'h0000_0000_0000_A000);
    chk("rr_mem31", 64'(mem[8'h31]), 64'h0000_0000_0000_B000);

    // Reset during CAPTURE of a port 1 read: no rvalid1, port 0 then served.
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h02;
    @(posedge Clock);
    #1;
    chk("mid_rst_ack1", 64'({bus.ack1, bus.busy}), 64'h3);
    drive_idle();
    @(posedge Clock);
    #1;
    chk("mid_rst_capture", 64'({bus.ack1, bus.busy, bus.rvalid1}), 64'h2);
    Resetn = 1'b0;
    #1;
    chk("mid_rst_values", 64'(get_obs()), 64'(rst_obs()));
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    rv_seen = 1'b0;
    repeat (4) begin
      @(posedge Clock);
      #1;
      if (bus.rvalid1) rv_seen = 1'b1;
    end
    chk("mid_rst_no_rvalid1", 64'({rv_seen, bus.rdata1}), 64'h0);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h01;
    @(posedge Clock);
    #1;
    chk("post_rst_ack0", 64'({bus.ack0, bus.grant_id, bus.busy}), 64'h5);
    drive_idle();
    @(posedge Clock);
    @(posedge Clock);
    #1;
    chk("post_rst_rdata0", 64'({bus.rvalid0, bus.rdata0}), 64'h1_1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port main data memory (256 x 16, synchronous: address, data and write-enable captured on the rising edge; read data valid in the following cycle). Port 0 is the processor load/store path and port 1 is a secondary master (DMA/IO). The block accepts request/ack handshakes, chooses a winner round-robin, drives the memory, and returns read data with a one-cycle valid pulse. Only one access is in flight at a time.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 16, memory data width

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous, active-low reset
req0  in  1  port 0 access request, level
we0  in  1  port 0: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 grant/accept pulse, 1 cycle
rvalid0  out  1  port 0 read data valid pulse, 1 cycle
rdata0  out  DATA_W  port 0 read data, held until next port 0 read completes
req1, we1, addr1, wdata1, ack1, rvalid1, rdata1  same as port 0, for port 1
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_q  in  DATA_W  memory read data
busy  out  1  1 when state != IDLE
grant_id  out  1  port owning the current/last access

Behaviour:
- All outputs are registered. Reset: state=IDLE, ack0/1=0, rvalid0/1=0, rdata0/1=0, mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, grant_id=1, so port 0 wins the first contested arbitration.
- FSM states are IDLE, ISSUE and CAPTURE.
- IDLE: sample req0/req1 at each edge.
  - Exactly one request: grant that port.
  - Both requesting: grant the port != grant_id (round-robin).
  - On grant: latch addr/wdata/we into mem_addr/mem_wdata/mem_wren (mem_wren = we of the winner), set grant_id, pulse the winner's ack, go to ISSUE.
  - No request: stay in IDLE with mem_wren=0.
- ISSUE, one cycle: mem_* stable; memory captures them at the closing edge; ack of the winner is high this cycle only.
  - Write: next state IDLE, mem_wren cleared.
  - Read: next state CAPTURE.
- CAPTURE, one cycle: mem_q valid. At the closing edge, rdata[grant_id] <= mem_q, rvalid[grant_id] pulses for the following cycle (which is IDLE), next state IDLE.
- Latency, request sampled at edge E0:
  - ack high E0..E1; write committed at E1.
  - Read: rvalid and rdata valid E2..E3.
  - Issue rate: writes every 2 cycles, reads every 3 cycles.
- Handshake rules:
  - The requester holds req/we/addr/wdata stable until it sees ack.
  - req still high in the IDLE cycle after ack is a new request.
  - req is ignored in ISSUE and CAPTURE; no queuing.
- mem_addr and mem_wdata hold their last values while IDLE. mem_wren is never high outside ISSUE.
- A loser's req stays pending. Round-robin guarantees it the next grant, so the wait is at most 1 access.
- rvalid and ack are never high for both ports in the same cycle. ack and rvalid of the same port never overlap.
- Reset mid-operation (any state): immediate return to reset values. An in-progress read yields no rvalid. A write in ISSUE is dropped if reset asserts before the edge.
- Addresses use the full ADDR_W width with no wrap or range check. Data passes through unmodified.

Test Plan:
- Port 0 write only (addr0=0x12, wdata0=0xBEEF, we0=1), then port 0 read of 0x12 -> ack0 one cycle after request, mem_wren high exactly one cycle with mem_addr=0x12; read gives rvalid0 2 cycles after ack0 with rdata0=0xBEEF; port 1 outputs stay 0.
- req0 and req1 both asserted from reset, both reads (0x01, 0x02 preloaded 0x1111, 0x2222) -> port 0 granted first, port 1 next; rdata0=0x1111, rdata1=0x2222; grant_id sequence 0, 1.
- Both ports hold req high continuously for 6 accesses -> grants strictly alternate 0,1,0,1,0,1; neither port waits more than one access.
- Port 1 write (0x40 <- 0x00A5) contested by port 0 read of 0x40 issued the same cycle after a port 1 grant -> port 0 granted first and reads the old value; a following port 0 read returns 0x00A5.
- Resetn pulsed low during CAPTURE of a port 1 read -> rvalid1 never asserts, busy=0 and mem_wren=0 immediately, grant_id=1; the next request from port 0 is granted normally.
- req1 asserted while state=ISSUE for port 0 -> no ack1 until the IDLE cycle following completion, then ack1 one cycle later.
